// File: rtl/toggle_event_rx.sv
// rtl/toggle_event_rx.sv - toggle-line event receiver with synchroniser, pending counter and valid/ready drain
// Optional toggle acknowledge output enabled by defining TOGGLE_EVENT_RX_ECHO_EN.
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             tog,
  input  logic             ev_ready,
  input  logic             clr_ovf,
  output logic             ev_pulse,
  output logic             ev_valid,
  output logic [CNT_W-1:0] pending,
`ifdef TOGGLE_EVENT_RX_ECHO_EN
  output logic             ack_tog,
`endif
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ref;
  logic                   r_pulse;
  logic [CNT_W-1:0]       r_pend;
  logic                   r_ovf;

  logic                   w_s;
  logic                   w_det;
  logic                   w_accept;
  logic                   w_sat;
  logic                   w_lost;
  logic [CNT_W-1:0]       w_pend_nxt;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_det    = w_s ^ r_ref;
  assign w_accept = ev_valid & ev_ready;
  assign w_sat    = (r_pend == CNT_MAX);
  // A detection that cannot be counted: saturated and nothing drained this cycle.
  assign w_lost   = w_det & ~w_accept & w_sat;

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_det && !w_accept && !w_sat) begin
      w_pend_nxt = r_pend + CNT_ONE;
    end else if (!w_det && w_accept) begin
      w_pend_nxt = r_pend - CNT_ONE;
    end
  end

  // The reference flop resets to 0 with the chain, so a tog held high through reset reads as one event.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_sync  <= '0;
      r_ref   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], tog};
      r_ref   <= w_s;
      r_pulse <= w_det;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_lost) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef TOGGLE_EVENT_RX_ECHO_EN
  logic r_ack;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_ack <= 1'b0;
    end else if (w_accept) begin
      r_ack <= ~r_ack;
    end
  end

  assign ack_tog = r_ack;
`endif

  assign ev_pulse = r_pulse;
  assign pending  = r_pend;
  assign ev_valid = (r_pend != '0);
  assign ovf      = r_ovf;

endmodule
